// File: rtl/switch_pkg.sv
// Shared crossbar-switch definitions: default word/packet geometry and the
// egress receive-side FSM state type.
package switch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int EGRESS_CNT = 4;
  localparam int PKT_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    DISCARD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are not reset; the owning FIFO's pointers define what is valid.
module sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/egress_receiver.sv
// Egress lane receiver: reassembles fixed-length packets into a FIFO and
// exposes only fully received packets on a valid/ready stream.
//   state   | meaning
//   IDLE    | waiting for word 0; admit/drop decided here
//   ACCEPT  | storing words of an admitted packet
//   DISCARD | swallowing words of a dropped packet
module egress_receiver #(
  parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
  parameter int PKT_WORDS  = switch_pkg::PKT_WORDS,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_en,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [CNT_WIDTH-1:0]          pkt_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  import switch_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(PKT_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_WORDS - 1);
  localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PKT_P    = PW'(PKT_WORDS);

  rx_state_t state, state_nxt;
  logic [IW-1:0] widx, widx_nxt, ridx;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, free;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic wr_en, commit, pkt_inc, drop_inc, rd_fire, last_word;

  // Space check uses registered pointers only, so a read this cycle is not credited.
  assign free      = DEPTH_P - (wr_ptr - rd_ptr);
  assign last_word = (widx == LAST_IDX);
  assign out_valid = (commit_ptr != rd_ptr);
  assign rd_fire   = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    wr_en     = 1'b0;
    commit    = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_en) begin
          widx_nxt = IW'(1);
          if (free >= PKT_P) begin
            wr_en     = 1'b1;
            state_nxt = ACCEPT;
          end else begin
            state_nxt = DISCARD;
          end
        end
      end
      ACCEPT: begin
        if (rx_en) begin
          wr_en = 1'b1;
          if (last_word) begin
            widx_nxt  = '0;
            commit    = 1'b1;
            pkt_inc   = 1'b1;
            state_nxt = IDLE;
          end else begin
            widx_nxt = widx + IW'(1);
          end
        end
      end
      DISCARD: begin
        if (rx_en) begin
          if (last_word) begin
            widx_nxt  = '0;
            drop_inc  = 1'b1;
            state_nxt = IDLE;
          end else begin
            widx_nxt = widx + IW'(1);
          end
        end
      end
      default: begin
        widx_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      widx       <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      ridx       <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nxt;
      widx  <= widx_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      // The last word's slot is wr_ptr itself, so the committed end is one past it.
      if (commit) commit_ptr <= wr_ptr + PW'(1);
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PW'(1);
        ridx   <= (ridx == LAST_IDX) ? '0 : ridx + IW'(1);
      end
      if (pkt_inc && (pkt_cnt != '1))   pkt_cnt  <= pkt_cnt + CNT_WIDTH'(1);
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign out_data = out_valid ? ram_rdata : '0;
  assign out_sop  = out_valid && (ridx == '0);
  assign out_eop  = out_valid && (ridx == LAST_IDX);
  assign level    = commit_ptr - rd_ptr;

endmodule

// File: tb/tb_egress_receiver.sv
// Bench for egress_receiver: table-driven single-packet vectors, directed
// corner sequences and randomized traffic against a queue-level packet model.
module tb_egress_receiver;

  localparam int DW    = 32;
  localparam int PKT   = 8;
  localparam int DEPTH = 32;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_en = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic [CW-1:0] pkt_cnt, drop_cnt;
  logic [5:0]    level;

  egress_receiver #(
    .DATA_WIDTH (DW),
    .PKT_WORDS  (PKT),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Packet-level reference: committed words with their position in the packet,
  // the words of the packet currently being received, and counters.
  typedef struct {
    logic [DW-1:0] d;
    int            idx;
  } word_t;

  word_t         cq[$];
  logic [DW-1:0] pq[$];
  int m_mode;   // 0 waiting for word 0, 1 keeping packet, 2 dropping packet
  int m_idx;
  int m_pkt, m_drop;

  task automatic model_clear();
    cq.delete();
    pq.delete();
    m_mode = 0;
    m_idx  = 0;
    m_pkt  = 0;
    m_drop = 0;
  endtask

  task automatic model_update(input logic en, input logic [DW-1:0] d, input logic rdy);
    bit fire;
    int used;
    fire = (cq.size() != 0) && rdy;
    used = cq.size() + pq.size();
    if (en) begin
      if (m_mode == 0) begin
        m_idx = 1;
        if (DEPTH - used >= PKT) begin
          pq.push_back(d);
          m_mode = 1;
        end else begin
          m_mode = 2;
        end
      end else begin
        if (m_mode == 1) pq.push_back(d);
        m_idx++;
        if (m_idx == PKT) begin
          if (m_mode == 1) begin
            foreach (pq[i]) cq.push_back('{d: pq[i], idx: i});
            pq.delete();
            if (m_pkt < CMAX) m_pkt++;
          end else begin
            if (m_drop < CMAX) m_drop++;
          end
          m_mode = 0;
          m_idx  = 0;
        end
      end
    end
    if (fire) void'(cq.pop_front());
  endtask

  task automatic check_all();
    bit v;
    v = (cq.size() != 0);
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("out_data", 64'(out_data), v ? 64'(cq[0].d) : 64'd0);
    chk("out_sop", 64'(out_sop), 64'(v && cq[0].idx == 0));
    chk("out_eop", 64'(out_eop), 64'(v && cq[0].idx == PKT - 1));
    chk("level", 64'(level), 64'(cq.size()));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input logic en, input logic [DW-1:0] d, input logic rdy);
    check_all();
    rx_en     = en;
    rx_data   = d;
    out_ready = rdy;
    model_update(en, d, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rx_en     = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] base, input logic rdy);
    for (int w = 0; w < PKT; w++) step(1'b1, base + DW'(w), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  typedef struct {
    logic          en;
    logic [DW-1:0] data;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_sop;
    logic          e_eop;
    int            e_level;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // One packet streamed in, then drained with out_ready held high.
    for (int k = 0; k < 17; k++) begin
      vecs[k].en   = (k < PKT);
      vecs[k].data = (k < PKT) ? 32'h100 + 32'(k) : '0;
      vecs[k].rdy  = 1'b1;
      if (k >= PKT && k < 2 * PKT) begin
        vecs[k].e_valid = 1'b1;
        vecs[k].e_data  = 32'h100 + 32'(k - PKT);
        vecs[k].e_sop   = (k == PKT);
        vecs[k].e_eop   = (k == 2 * PKT - 1);
        vecs[k].e_level = 2 * PKT - k;
      end else begin
        vecs[k].e_valid = 1'b0;
        vecs[k].e_data  = '0;
        vecs[k].e_sop   = 1'b0;
        vecs[k].e_eop   = 1'b0;
        vecs[k].e_level = 0;
      end
    end

    model_clear();
    @(negedge clk);
    do_reset();

    for (int k = 0; k < 17; k++) begin
      chk("vec_valid", 64'(out_valid), 64'(vecs[k].e_valid));
      chk("vec_data", 64'(out_data), 64'(vecs[k].e_data));
      chk("vec_sop", 64'(out_sop), 64'(vecs[k].e_sop));
      chk("vec_eop", 64'(out_eop), 64'(vecs[k].e_eop));
      chk("vec_level", 64'(level), 64'(vecs[k].e_level));
      step(vecs[k].en, vecs[k].data, vecs[k].rdy);
    end
    chk("single_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Same packet with a 3-cycle gap after word 3.
    do_reset();
    for (int w = 0; w < 4; w++) step(1'b1, 32'h100 + 32'(w), 1'b1);
    idle(3, 1'b1);
    for (int w = 4; w < PKT; w++) begin
      chk("gap_no_early_valid", 64'(out_valid), 64'd0);
      step(1'b1, 32'h100 + 32'(w), 1'b1);
    end
    chk("gap_valid_after_last", 64'(out_valid), 64'd1);
    chk("gap_sop_word", 64'(out_data), 64'h100);
    idle(10, 1'b1);
    chk("gap_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Fill with out_ready low: four fit, the fifth is dropped.
    do_reset();
    for (int p = 0; p < 5; p++) send_pkt(32'h1000 * (p + 1), 1'b0);
    idle(1, 1'b0);
    chk("full_level", 64'(level), 64'd32);
    chk("full_pkt_cnt", 64'(pkt_cnt), 64'd4);
    chk("full_drop_cnt", 64'(drop_cnt), 64'd1);

    // Reading in the word-0 cycle does not free space for that decision.
    send_pkt(32'h6000, 1'b1);
    send_pkt(32'h7000, 1'b1);
    idle(40, 1'b1);
    chk("race_pkt_cnt", 64'(pkt_cnt), 64'd5);
    chk("race_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("race_level", 64'(level), 64'd0);

    // Reset in the middle of a packet with committed data held.
    do_reset();
    send_pkt(32'h8000, 1'b0);
    for (int w = 0; w < 4; w++) step(1'b1, 32'h9000 + 32'(w), 1'b0);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_data", 64'(out_data), 64'd0);
    chk("async_reset_level", 64'(level), 64'd0);
    chk("async_reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    do_reset();
    send_pkt(32'hA000, 1'b1);
    idle(12, 1'b1);
    chk("post_reset_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Randomized traffic: gaps inside packets, 50% out_ready.
    do_reset();
    for (int p = 0; p < 20; p++) begin
      for (int w = 0; w < PKT; w++) begin
        int gaps;
        gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int g = 0; g < gaps; g++) step(1'b0, $urandom, 1'($urandom_range(0, 1)));
        step(1'b1, (32'(p) << 8) | 32'(w), 1'($urandom_range(0, 1)));
      end
    end
    idle(60, 1'b1);
    chk("rand_total_pkts", 64'(pkt_cnt) + 64'(drop_cnt), 64'd20);
    chk("rand_drained", 64'(level), 64'd0);
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
